// File: rtl/axi_mem_bist_if.sv
// rtl/axi_mem_bist_if.sv - AXI4 memory port bundle used by axi_mem_bist
//
// Purpose: groups the five AXI4 channels of the 32-bit memory port into one
//          interface. The BIST drives it through the master modport; the
//          SDRAM controller side (or a bench slave model) uses the slave modport.
// Signals:
//   aw*  : awid[6] awaddr[28] awlen[8] awsize[3] awburst[2] awvalid / awready
//   w*   : wdata[32] wstrb[4] wlast wvalid / wready
//   b*   : bid[6] bresp[2] bvalid / bready
//   ar*  : arid[6] araddr[28] arlen[8] arsize[3] arburst[2] arvalid / arready
//   r*   : rid[6] rdata[32] rresp[2] rlast rvalid / rready
interface axi_mem_bist_if;
   logic [5:0]  awid;
   logic [27:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        awvalid;
   logic        awready;

   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;

   logic [5:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   logic [5:0]  arid;
   logic [27:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;

   logic [5:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );
endinterface

// File: rtl/axi_mem_bist.sv
// rtl/axi_mem_bist.sv - AXI4 write/read-back memory BIST initiator
//
// Purpose: writes num_bursts INCR bursts of BURST_LEN 32-bit beats starting at
//          an aligned base address with the pattern {4'h0,addr}^seed, then
//          reads the same range back and checks every beat. One transaction
//          is outstanding at a time.
// Ports:
//   soc_clk       in   clock, rising edge
//   soc_aresetn   in   asynchronous active-low reset
//   start_i       in   start pulse, ignored while busy_o
//   base_addr_i   in   [27:0] start byte address (burst-aligned on capture)
//   num_bursts_i  in   [15:0] bursts per phase
//   seed_i        in   [31:0] pattern seed
//   busy_o        out  test running
//   done_o        out  test finished (level until next start)
//   err_o         out  sticky error flag for the current run
//   err_cnt_o     out  [15:0] failing read beats + bad bresp, saturating
//   err_addr_o    out  [27:0] address of first failing read beat
//   mem_axi       master modport of axi_mem_bist_if
// Build option: AXI_MEM_BIST_STOP_ON_ERR_EN - end the read phase after the
//          burst holding the first failing read beat has been drained.
module axi_mem_bist #(
   parameter int unsigned BURST_LEN = 16,
   parameter logic [5:0]  AXI_ID    = 6'h00
) (
   input  logic           soc_clk,
   input  logic           soc_aresetn,
   input  logic           start_i,
   input  logic [27:0]    base_addr_i,
   input  logic [15:0]    num_bursts_i,
   input  logic [31:0]    seed_i,
   output logic           busy_o,
   output logic           done_o,
   output logic           err_o,
   output logic [15:0]    err_cnt_o,
   output logic [27:0]    err_addr_o,
   axi_mem_bist_if.master mem_axi
);
   localparam logic [27:0] ADDR_STEP  = 28'(BURST_LEN * 4);
   localparam logic [27:0] ALIGN_MASK = ~(ADDR_STEP - 28'd1);
   localparam logic [7:0]  LAST_BEAT  = 8'(BURST_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WA,
      S_WD,
      S_WB,
      S_RA,
      S_RD,
      S_DONE
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [27:0] r_base;
   logic [27:0] r_addr;
   logic [15:0] r_num;
   logic [15:0] r_left;
   logic [31:0] r_seed;
   logic [7:0]  r_beat;
   logic        r_err;
   logic [15:0] r_err_cnt;
   logic [27:0] r_err_addr;
   logic        r_rd_fail;

   logic        w_awvalid;
   logic        w_wvalid;
   logic        w_bready;
   logic        w_arvalid;
   logic        w_rready;

   logic        w_start;
   logic        w_last_beat;
   logic        w_more;
   logic [27:0] w_beat_addr;
   logic [31:0] w_pattern;
   logic        w_w_hs;
   logic        w_b_hs;
   logic        w_r_hs;
   logic        w_rd_fail;
   logic [15:0] w_cnt_inc;
   logic        w_unused;

   // A start is only honoured when no test is running.
   assign w_start     = start_i && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_last_beat = (r_beat == LAST_BEAT);
   // r_left counts the bursts still to go in this phase, including the current one.
   assign w_more      = (r_left != 16'd1);
   assign w_beat_addr = r_addr + {18'd0, r_beat, 2'b00};
   assign w_pattern   = {4'h0, w_beat_addr} ^ r_seed;

   assign w_w_hs = (r_state == S_WD) && mem_axi.wready;
   assign w_b_hs = (r_state == S_WB) && mem_axi.bvalid;
   assign w_r_hs = (r_state == S_RD) && mem_axi.rvalid;

   // rlast must appear on the final beat and nowhere else.
   assign w_rd_fail = (mem_axi.rdata != w_pattern) ||
                      (mem_axi.rresp != 2'b00) ||
                      (mem_axi.rlast != w_last_beat);

   assign w_cnt_inc = (r_err_cnt == 16'hFFFF) ? r_err_cnt : r_err_cnt + 16'd1;

   // Response IDs are not checked: only AXI_ID is ever issued.
   assign w_unused = ^{mem_axi.bid, mem_axi.rid};

`ifdef AXI_MEM_BIST_STOP_ON_ERR_EN
   logic w_stop;
   // Includes the beat being accepted so a failure on the final beat also stops.
   assign w_stop = r_rd_fail || w_rd_fail;
`endif

   always_ff @(posedge soc_clk or negedge soc_aresetn) begin
      if (!soc_aresetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_awvalid   = 1'b0;
      w_wvalid    = 1'b0;
      w_bready    = 1'b0;
      w_arvalid   = 1'b0;
      w_rready    = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               w_state_nxt = (num_bursts_i == 16'd0) ? S_DONE : S_WA;
            end
         end
         S_WA: begin
            w_awvalid = 1'b1;
            if (mem_axi.awready) begin
               w_state_nxt = S_WD;
            end
         end
         S_WD: begin
            w_wvalid = 1'b1;
            if (mem_axi.wready && w_last_beat) begin
               w_state_nxt = S_WB;
            end
         end
         S_WB: begin
            w_bready = 1'b1;
            if (mem_axi.bvalid) begin
               w_state_nxt = w_more ? S_WA : S_RA;
            end
         end
         S_RA: begin
            w_arvalid = 1'b1;
            if (mem_axi.arready) begin
               w_state_nxt = S_RD;
            end
         end
         S_RD: begin
            w_rready = 1'b1;
            if (mem_axi.rvalid && w_last_beat) begin
`ifdef AXI_MEM_BIST_STOP_ON_ERR_EN
               w_state_nxt = (!w_more || w_stop) ? S_DONE : S_RA;
`else
               w_state_nxt = w_more ? S_RA : S_DONE;
`endif
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge soc_clk or negedge soc_aresetn) begin
      if (!soc_aresetn) begin
         r_base     <= '0;
         r_addr     <= '0;
         r_num      <= '0;
         r_left     <= '0;
         r_seed     <= '0;
         r_beat     <= '0;
         r_err      <= 1'b0;
         r_err_cnt  <= '0;
         r_err_addr <= '0;
         r_rd_fail  <= 1'b0;
      end else begin
         if (w_start) begin
            r_base     <= base_addr_i & ALIGN_MASK;
            r_addr     <= base_addr_i & ALIGN_MASK;
            r_num      <= num_bursts_i;
            r_left     <= num_bursts_i;
            r_seed     <= seed_i;
            r_beat     <= '0;
            r_err      <= 1'b0;
            r_err_cnt  <= '0;
            r_err_addr <= '0;
            r_rd_fail  <= 1'b0;
         end

         if (w_w_hs || w_r_hs) begin
            r_beat <= w_last_beat ? 8'd0 : r_beat + 8'd1;
         end

         if (w_b_hs) begin
            if (mem_axi.bresp != 2'b00) begin
               r_err     <= 1'b1;
               r_err_cnt <= w_cnt_inc;
            end
            if (w_more) begin
               r_left <= r_left - 16'd1;
               r_addr <= r_addr + ADDR_STEP;
            end else begin
               // Write phase complete: rewind for the read-back phase.
               r_left <= r_num;
               r_addr <= r_base;
            end
         end

         if (w_r_hs) begin
            if (w_rd_fail) begin
               r_err     <= 1'b1;
               r_err_cnt <= w_cnt_inc;
               if (!r_rd_fail) begin
                  r_err_addr <= w_beat_addr;
                  r_rd_fail  <= 1'b1;
               end
            end
            if (w_last_beat && w_more) begin
               r_left <= r_left - 16'd1;
               r_addr <= r_addr + ADDR_STEP;
            end
         end
      end
   end

   assign mem_axi.awid    = AXI_ID;
   assign mem_axi.awaddr  = r_addr;
   assign mem_axi.awlen   = LAST_BEAT;
   assign mem_axi.awsize  = 3'd2;
   assign mem_axi.awburst = 2'b01;
   assign mem_axi.awvalid = w_awvalid;

   assign mem_axi.wdata   = w_pattern;
   assign mem_axi.wstrb   = 4'hF;
   assign mem_axi.wlast   = w_wvalid && w_last_beat;
   assign mem_axi.wvalid  = w_wvalid;

   assign mem_axi.bready  = w_bready;

   assign mem_axi.arid    = AXI_ID;
   assign mem_axi.araddr  = r_addr;
   assign mem_axi.arlen   = LAST_BEAT;
   assign mem_axi.arsize  = 3'd2;
   assign mem_axi.arburst = 2'b01;
   assign mem_axi.arvalid = w_arvalid;

   assign mem_axi.rready  = w_rready;

   assign busy_o     = (r_state != S_IDLE) && (r_state != S_DONE);
   assign done_o     = (r_state == S_DONE);
   assign err_o      = r_err;
   assign err_cnt_o  = r_err_cnt;
   assign err_addr_o = r_err_addr;
endmodule
